// File: rtl/counter_pkg.sv
// counter_pkg: shared FSM encoding, BCD limits and timer sizing for press_counter
package counter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1, REPEAT = 2'd2} state_t;
    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [3:0] DIGIT_MIN = 4'd0;
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD decade register with up/down step and ripple carry/borrow out
module bcd_digit
    import counter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       up,
    output logic [3:0] digit,
    output logic       carry
);
    assign carry = en && (up ? digit == DIGIT_MAX : digit == DIGIT_MIN);
    always_ff @(posedge clock or posedge reset)
        if (reset)
            digit <= DIGIT_MIN;
        else if (clear)
            digit <= DIGIT_MIN;
        else if (en)
            digit <= up ? (digit == DIGIT_MAX ? DIGIT_MIN : digit + 4'd1)
                        : (digit == DIGIT_MIN ? DIGIT_MAX : digit - 4'd1);
endmodule

// File: rtl/press_counter.sv
// press_counter: debounced press/hold-repeat FSM driving a DIGITS-wide BCD up/down counter
module press_counter
    import counter_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clean,
    input  logic                up,
    input  logic                clear,
    output logic [4*DIGITS-1:0] count,
    output logic                step,
    output logic                wrap
);
    localparam int TW = timer_width(HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

    state_t        state;
    logic [TW-1:0] timer;
    logic          fire;
    logic [DIGITS:0] c;

    // release wins over expiry because fire requires clean
    assign fire = clean && (state == IDLE ||
                            (state == HELD   && timer == HOLD_LAST) ||
                            (state == REPEAT && timer == REP_LAST));
    assign c[0] = fire;

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_digit
            bcd_digit u_digit (
                .clock (clock),
                .reset (reset),
                .clear (clear),
                .en    (c[i]),
                .up    (up),
                .digit (count[4*i +: 4]),
                .carry (c[i+1])
            );
        end
    endgenerate

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            step  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            step <= fire;
            wrap <= c[DIGITS] && !clear;
            case (state)
                IDLE:
                    if (clean) begin
                        state <= HELD;
                        timer <= '0;
                    end
                HELD:
                    if (!clean) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (timer == HOLD_LAST) begin
                        state <= REPEAT;
                        timer <= '0;
                    end else
                        timer <= timer + 1'b1;
                REPEAT:
                    if (!clean) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (timer == REP_LAST)
                        timer <= '0;
                    else
                        timer <= timer + 1'b1;
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
endmodule

// File: tb/tb_press_counter.sv
// tb_press_counter: directed self-checking bench for press_counter (HOLD=8, REPEAT=4)
module tb_press_counter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clean = 1'b0;
    logic        up    = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] count;
    logic        step;
    logic        wrap;
    int          n_cmp = 0;
    int          n_err = 0;

    press_counter #(.DIGITS(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut (
        .clock (clock),
        .reset (reset),
        .clean (clean),
        .up    (up),
        .clear (clear),
        .count (count),
        .step  (step),
        .wrap  (wrap)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic dir);
        up = dir;
        clean = 1'b1;
        tick();
    endtask

    task automatic release_btn();
        clean = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    logic [20:0] mask;
    int          nsteps;

    initial begin
        tick();
        tick();
        check("rst_count", count, 0);
        check("rst_step", step, 0);
        check("rst_wrap", wrap, 0);
        reset = 1'b0;
        tick();

        // single press, 3 cycles high
        press(1'b1);
        check("p1_count", count, 16'h0001);
        check("p1_step", step, 1);
        check("p1_wrap", wrap, 0);
        tick();
        check("p1_step_lo", step, 0);
        tick();
        release_btn();
        check("p1_hold_count", count, 16'h0001);

        // long hold: steps at offsets 0,8,12,16,20
        do_clear();
        mask = '0;
        clean = 1'b1;
        for (int k = 0; k < 21; k++) begin
            tick();
            mask[k] = step;
        end
        check("hold_mask", mask, 21'h111101);
        check("hold_count", count, 16'h0005);
        clean = 1'b0;
        nsteps = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            nsteps += int'(step);
        end
        check("rel_steps", nsteps, 0);
        check("rel_count", count, 16'h0005);

        // wrap both directions
        do_clear();
        press(1'b0);
        check("dn_wrap_count", count, 16'h9999);
        check("dn_wrap_flag", {step, wrap}, 2'b11);
        release_btn();
        check("wrap_lo", wrap, 0);
        press(1'b1);
        check("up_wrap_count", count, 16'h0000);
        check("up_wrap_flag", {step, wrap}, 2'b11);
        release_btn();
        press(1'b0);
        check("dn_wrap2_count", count, 16'h9999);
        check("dn_wrap2_flag", wrap, 1);
        release_btn();

        // carry across digits and fast toggling
        do_clear();
        for (int k = 0; k < 19; k++) begin
            press(1'b1);
            release_btn();
        end
        check("pre19", count, 16'h0019);
        press(1'b1);
        check("carry_count", count, 16'h0020);
        check("carry_wrap", wrap, 0);
        release_btn();
        press(1'b1);
        release_btn();
        press(1'b1);
        release_btn();
        check("toggle_count", count, 16'h0022);

        // clear coincident with press
        clear = 1'b1;
        press(1'b1);
        clear = 1'b0;
        check("clr_count", count, 16'h0000);
        check("clr_flags", {step, wrap}, 2'b10);
        nsteps = 0;
        for (int k = 0; k < 7; k++) begin
            tick();
            nsteps += int'(step);
        end
        check("clr_gap", nsteps, 0);
        tick();
        check("clr_rep_count", count, 16'h0001);
        check("clr_rep_step", step, 1);

        // async reset mid-REPEAT with button still held
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_flags", {step, wrap}, 2'b00);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_count", count, 16'h0001);
        check("post_rst_step", step, 1);
        nsteps = 0;
        for (int k = 0; k < 7; k++) begin
            tick();
            nsteps += int'(step);
        end
        check("post_rst_gap", nsteps, 0);
        tick();
        check("post_rst_rep", {count, 7'd0, step}, {16'h0002, 7'd0, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
